// File: rtl/wb_ctrl.sv
// Writeback sequencer: counts PE output bytes into 64-bit words and steers word writes to the two BRAM32k ports.
// Latency: write enable and address appear 2 cycles after the cycle that accepts lane 7; done follows 1 cycle after the last write.
// Backpressure: none; sum_valid is accepted whenever RUN is active. Bytes arriving outside RUN are dropped and raise sticky err.
module wb_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  layer,
  input  logic [11:0] base_addr,
  input  logic [11:0] word_cnt,
  input  logic        sum_valid,
  output logic        wb_en,
  output logic [2:0]  lane,
  output logic        we_BRAM32k_1,
  output logic        we_BRAM32k_2,
  output logic [11:0] addr_BRAM32k_1,
  output logic [11:0] addr_BRAM32k_2,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Job context captured at start. Layer is only needed as "single port"
  // versus "ping-pong between ports", so only that bit is kept.
  logic        split_q;
  logic [11:0] base_q;
  logic [11:0] cnt_q;
  logic [11:0] word_q;
  logic [2:0]  lane_q;
  logic        drain_q;
  logic        err_q;

  logic        legal_layer;
  logic        load;
  logic        accept;
  logic        err_set;
  logic        word_done;
  logic [11:0] word_offs;

  // Stage 1 of the write pipeline; stage 2 is the output registers.
  logic        s1_vld;
  logic        s1_port2;
  logic [11:0] s1_addr;

  assign legal_layer = (layer != 4'd0) && (layer <= 4'd5);
  assign word_done   = accept && (lane_q == 3'd7);
  // Split layers place two consecutive words at the same address on
  // alternate ports, so the address advances every other word.
  assign word_offs   = split_q ? {1'b0, word_q[11:1]} : word_q;
  assign lane        = lane_q;
  assign err         = err_q;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    wb_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    accept  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal_layer) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            err_set = 1'b1;
          end
        end
        if (sum_valid) begin
          err_set = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == 12'd0) begin
          // Empty job: nothing to collect, go straight to drain.
          state_d = DRAIN;
          if (sum_valid) begin
            err_set = 1'b1;
          end
        end else begin
          wb_en  = sum_valid;
          accept = sum_valid;
          if (sum_valid && (lane_q == 3'd7) && (word_q == cnt_q - 12'd1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (sum_valid) begin
          err_set = 1'b1;
        end
        if (drain_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
        if (sum_valid) begin
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job context, byte lane and word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      split_q <= 1'b0;
      base_q  <= 12'd0;
      cnt_q   <= 12'd0;
      word_q  <= 12'd0;
      lane_q  <= 3'd0;
    end else if (load) begin
      split_q <= (layer != 4'd1);
      base_q  <= base_addr;
      cnt_q   <= word_cnt;
      word_q  <= 12'd0;
      lane_q  <= 3'd0;
    end else if (accept) begin
      lane_q <= lane_q + 3'd1;
      if (lane_q == 3'd7) begin
        word_q <= word_q + 12'd1;
      end
    end
  end

  // Two-cycle drain timer: first DRAIN cycle arms it, second one exits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state_q == DRAIN) && !drain_q;
    end
  end

  // Sticky error; a stray byte in the same cycle as a start still wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (load) begin
      err_q <= 1'b0;
    end
  end

  // Pipeline stage 1: capture port and address of the completed word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_port2 <= 1'b0;
      s1_addr  <= 12'd0;
    end else begin
      s1_vld   <= word_done;
      s1_port2 <= split_q & word_q[0];
      s1_addr  <= base_q + word_offs;
    end
  end

  // Pipeline stage 2: one-cycle write pulses; an idle port keeps its address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_BRAM32k_1   <= 1'b0;
      we_BRAM32k_2   <= 1'b0;
      addr_BRAM32k_1 <= 12'd0;
      addr_BRAM32k_2 <= 12'd0;
    end else begin
      we_BRAM32k_1 <= s1_vld & ~s1_port2;
      we_BRAM32k_2 <= s1_vld &  s1_port2;
      if (s1_vld && !s1_port2) begin
        addr_BRAM32k_1 <= s1_addr;
      end
      if (s1_vld && s1_port2) begin
        addr_BRAM32k_2 <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  layer;
  logic [11:0] base_addr;
  logic [11:0] word_cnt;
  logic        sum_valid;
  logic        wb_en;
  logic [2:0]  lane;
  logic        we_BRAM32k_1;
  logic        we_BRAM32k_2;
  logic [11:0] addr_BRAM32k_1;
  logic [11:0] addr_BRAM32k_2;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // kind: 0 = port 1 write, 1 = port 2 write, 2 = done pulse
  typedef struct {
    int          kind;
    logic [11:0] addr;
    int          at;
  } ev_t;

  ev_t ev_q[$];
  int  lane_exp_q[$];

  wb_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .layer          (layer),
    .base_addr      (base_addr),
    .word_cnt       (word_cnt),
    .sum_valid      (sum_valid),
    .wb_en          (wb_en),
    .lane           (lane),
    .we_BRAM32k_1   (we_BRAM32k_1),
    .we_BRAM32k_2   (we_BRAM32k_2),
    .addr_BRAM32k_1 (addr_BRAM32k_1),
    .addr_BRAM32k_2 (addr_BRAM32k_2),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input logic [11:0] addr, input int at);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.at   = at;
    ev_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input logic [11:0] addr);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d addr=0x%0h at cycle %0d, expected no event",
               kind, addr, cyc);
    end else begin
      e = ev_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.at);
      if (kind != 2) check("event_addr", int'(addr), int'(e.addr));
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (wb_en) begin
      if (lane_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb_en: got wb_en=1 lane=%0d at cycle %0d, expected wb_en=0",
                 lane, cyc);
      end else begin
        check("lane", int'(lane), lane_exp_q.pop_front());
      end
    end
    if (we_BRAM32k_1) mon_event(0, addr_BRAM32k_1);
    if (we_BRAM32k_2) mon_event(1, addr_BRAM32k_2);
    if (done)         mon_event(2, 12'd0);
  end

  // Issue one job; expected writes and done are queued as the stimulus goes out.
  task automatic run_job(input logic [3:0] ly, input logic [11:0] base, input logic [11:0] cnt,
                         input bit gaps, input bit extra);
    int          nb;
    int          g;
    int          k;
    logic [11:0] a;
    start     = 1'b1;
    layer     = ly;
    base_addr = base;
    word_cnt  = cnt;
    tick();
    start = 1'b0;
    check("err_cleared_by_start", int'(err), 0);
    check("busy_in_run", int'(busy), 1);
    if (cnt == 12'd0) push_ev(2, 12'd0, cyc + 3);
    nb = int'(cnt) * 8;
    for (int b = 0; b < nb; b++) begin
      g = 0;
      if (gaps) g = (((b * 5 + 1) % 4) == 0) ? 2 : (((b % 3) == 0) ? 1 : 0);
      repeat (g) tick();
      sum_valid = 1'b1;
      lane_exp_q.push_back(b % 8);
      if ((b % 8) == 7) begin
        k = b / 8;
        if (ly == 4'd1) begin
          a = base + 12'(k);
          push_ev(0, a, cyc + 2);
        end else begin
          a = base + 12'(k / 2);
          push_ev(k % 2, a, cyc + 2);
        end
        if (b == nb - 1) push_ev(2, 12'd0, cyc + 3);
      end
      tick();
      sum_valid = 1'b0;
    end
    if (extra) begin
      sum_valid = 1'b1;
      #2;
      check("extra_valid_wb_en", int'(wb_en), 0);
      tick();
      sum_valid = 1'b0;
      check("extra_valid_err", int'(err), 1);
    end
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    layer     = 4'd0;
    base_addr = 12'd0;
    word_cnt  = 12'd0;
    sum_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_en", int'(wb_en), 0);
    check("rst_lane", int'(lane), 0);
    check("rst_we1", int'(we_BRAM32k_1), 0);
    check("rst_we2", int'(we_BRAM32k_2), 0);
    check("rst_addr1", int'(addr_BRAM32k_1), 0);
    check("rst_addr2", int'(addr_BRAM32k_2), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    // Release and start in the same cycle: accepted on the next edge.
    rst = 1'b1;
    run_job(4'd1, 12'h010, 12'd2, 1'b0, 1'b0);
    run_job(4'd3, 12'h100, 12'd3, 1'b0, 1'b0);
    run_job(4'd1, 12'hFFF, 12'd2, 1'b0, 1'b0);
    run_job(4'd2, 12'h055, 12'd0, 1'b0, 1'b0);

    // Illegal layers: err set, block stays idle.
    start     = 1'b1;
    layer     = 4'd7;
    base_addr = 12'h123;
    word_cnt  = 12'd1;
    tick();
    start = 1'b0;
    check("layer7_err", int'(err), 1);
    check("layer7_busy", int'(busy), 0);
    tick();
    check("layer7_busy_later", int'(busy), 0);
    start = 1'b1;
    layer = 4'd0;
    tick();
    start = 1'b0;
    check("layer0_err", int'(err), 1);
    check("layer0_busy", int'(busy), 0);

    // Gapped stream with a stray byte after the last word.
    run_job(4'd5, 12'h020, 12'd4, 1'b1, 1'b1);

    // Reset in the middle of a word.
    start     = 1'b1;
    layer     = 4'd1;
    base_addr = 12'h040;
    word_cnt  = 12'd2;
    tick();
    start     = 1'b0;
    sum_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lane_exp_q.push_back(i);
      tick();
    end
    sum_valid = 1'b0;
    check("mid_lane_before_rst", int'(lane), 4);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_lane", int'(lane), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_wb_en", int'(wb_en), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_we1", int'(we_BRAM32k_1), 0);
    check("mid_rst_we2", int'(we_BRAM32k_2), 0);
    check("mid_rst_addr1", int'(addr_BRAM32k_1), 0);
    check("mid_rst_addr2", int'(addr_BRAM32k_2), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (8) tick();
    run_job(4'd4, 12'h200, 12'd2, 1'b0, 1'b0);

    check("scoreboard_drained", ev_q.size(), 0);
    check("lane_queue_drained", lane_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on the rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  one-cycle job start request.
REQ-004 SHALL have ports: layer  in  4  layer code; legal values 1..5.
REQ-005 SHALL have ports: base_addr  in  12  first BRAM32k word address.
REQ-006 SHALL have ports: word_cnt  in  12  number of 64-bit words to write.
REQ-007 SHALL have ports: sum_valid  in  1  PE groups present one output byte this cycle.
REQ-008 SHALL have ports: wb_en  out  1  enable to the writeback datapath.
REQ-009 SHALL have ports: lane  out  3  byte lane 0..7 for the current byte.
REQ-010 SHALL have ports: we_BRAM32k_1, we_BRAM32k_2  out  1 each  per-port write enables.
REQ-011 SHALL have ports: addr_BRAM32k_1, addr_BRAM32k_2  out  12 each  port write addresses.
REQ-012 SHALL have ports: busy  out  1;  done  out  1;  err  out  1  (sticky error).

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: on start=1 with legal layer, SHALL latch layer, base_addr and word_cnt, clear lane, word counter and err, then go to RUN; busy=1 from the next cycle.
REQ-015 IDLE: start=1 with layer 0 or 6..15 SHALL set err and stay in IDLE.
REQ-016 start=1 outside IDLE SHALL be ignored.
REQ-017 start with word_cnt=0 SHALL go RUN->DRAIN->DONE without any write enable.
REQ-018 RUN: wb_en SHALL equal sum_valid, combinationally; lane SHALL advance 0..7 on each accepted byte and wrap 7->0.
REQ-019 An accepted byte with lane=7 SHALL complete word k, where k counts 0..word_cnt-1.
REQ-020 Completion of word k SHALL enter a 2-stage pipeline that matches the datapath latency; the write enable SHALL assert exactly 2 cycles after the cycle in which lane 7 was accepted.
REQ-021 Each write enable SHALL be a 1-cycle pulse.
REQ-022 Layer 1: every word SHALL go to port 1 at addr = base_addr + k.
REQ-023 Layers 2-5: even k SHALL go to port 1 and odd k to port 2, at addr = base_addr + k/2 (integer division).
REQ-024 Address arithmetic SHALL be 12-bit and wrap modulo 4096.
REQ-025 An unused port's address SHALL hold its last value.
REQ-026 Addresses SHALL be valid in the same cycle as their write enable.
REQ-027 After word word_cnt-1 completes, the block SHALL enter DRAIN and stay there until the pipeline is empty (2 cycles).
REQ-028 DRAIN -> DONE: done=1 for exactly 1 cycle, then IDLE with busy=0.
REQ-029 sum_valid=1 in IDLE, DRAIN or DONE SHALL be discarded: wb_en=0, err set.
REQ-030 err SHALL be cleared only by reset or by an accepted legal start.
REQ-031 sum_valid=0 gaps in RUN SHALL hold lane and the counters unchanged.

Reset
REQ-032 rst=0 SHALL immediately force IDLE; wb_en, lane, we_BRAM32k_1/2, addr_BRAM32k_1/2, busy, done and err all 0; pipeline flushed.
REQ-033 Reset mid-job SHALL abandon the job, with no write enable after release.
REQ-034 The first start SHALL be accepted on the first rising edge after rst returns high.

Verification
REQ-035 layer=1, base=0x010, cnt=2, 16 consecutive valids -> we_1 pulses at addr 0x010 and 0x011, each 2 cycles after its 8th byte; done 1 cycle after the last write enable's drain completes; we_2 never asserts.
REQ-036 layer=3, base=0x100, cnt=3 -> port 1 writes 0x100 (k=0) and 0x101 (k=2); port 2 writes 0x100 (k=1).
REQ-037 layer=1, base=0xFFF, cnt=2 -> writes at 0xFFF then 0x000.
REQ-038 cnt=0 -> done pulses with no write enables. layer=7 -> err=1, busy stays 0.
REQ-039 Valid stream with random gaps -> lanes stay contiguous and the write-enable count equals cnt. Extra valid after the last word -> err=1, wb_en=0.
REQ-040 rst low mid-word (lane=4) -> all outputs 0 immediately; no write enable after release; a new start runs normally from lane 0.
